// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and helpers for the MEM-stage load/store unit
package mem_access_unit_pkg;

    typedef logic [31:0] data_t;
    typedef logic [1:0]  mem_size_t;
    typedef logic [3:0]  byte_en_t;

    localparam mem_size_t MEM_BYTE = 2'b00;
    localparam mem_size_t MEM_HALF = 2'b01;
    localparam mem_size_t MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Size code 2'b11 falls through to the word rule.
    function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return off[0];
            default:  return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data memory req/gnt/rvalid bus
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic     req;
    logic     we;
    data_t    addr;
    byte_en_t be;
    data_t    wdata;
    logic     gnt;
    logic     rvalid;
    data_t    rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication, load lane select and extension
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_size_t  st_size_i,
    input  logic [1:0] st_off_i,
    input  data_t      st_data_i,
    output byte_en_t   be_o,
    output data_t      wdata_o,
    input  mem_size_t  ld_size_i,
    input  logic [1:0] ld_off_i,
    input  logic       ld_unsigned_i,
    input  data_t      rdata_i,
    output data_t      ldata_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
        case (st_size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            MEM_HALF: begin
                be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_size_i)
            MEM_BYTE: ldata_o = ld_unsigned_i ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            MEM_HALF: ldata_o = ld_unsigned_i ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            MEM_WORD: ldata_o = rdata_i;
            default:  ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with stall, alignment and timeout handling
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      valid_i,
    input  logic      memRead_i,
    input  logic      memWrite_i,
    input  mem_size_t memSize_i,
    input  logic      memUnsigned_i,
    input  data_t     addr_i,
    input  data_t     storeData_i,
    output logic      stall_o,
    output logic      done_o,
    output logic      misaligned_o,
    output logic      busErr_o,
    output data_t     rdData_o,
    mem_access_unit_if.master dmem
);
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    data_t      rd_data_q, rd_data_d;
    logic       done_q, done_d, bus_err_q, bus_err_d;
    logic       req_q, req_d, we_q, we_d;
    data_t      addr_q, addr_d, wdata_q, wdata_d;
    byte_en_t   be_q, be_d;
    mem_size_t  ld_size_q, ld_size_d;
    logic [1:0] ld_off_q, ld_off_d;
    logic       ld_uns_q, ld_uns_d;

    logic       access, misalign, timeout;
    byte_en_t   st_be;
    data_t      st_wdata, ld_data;

    mem_lane_align u_align (
        .st_size_i     (memSize_i),
        .st_off_i      (addr_i[1:0]),
        .st_data_i     (storeData_i),
        .be_o          (st_be),
        .wdata_o       (st_wdata),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_uns_q),
        .rdata_i       (dmem.rdata),
        .ldata_o       (ld_data)
    );

    assign access   = valid_i & (memRead_i | memWrite_i);
    assign misalign = is_misaligned(memSize_i, addr_i[1:0]);
    // Fires on the cycle whose increment would make the count reach TIMEOUT.
    assign timeout  = (cnt_q >= 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            ld_size_q <= MEM_BYTE;
            ld_off_q  <= '0;
            ld_uns_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            bus_err_q <= bus_err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        bus_err_d = 1'b0;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        case (state_q)
            ST_IDLE: begin
                if (access && !misalign) begin
                    state_d   = ST_REQ;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = memWrite_i;
                    addr_d    = {addr_i[31:2], 2'b00};
                    be_d      = st_be;
                    wdata_d   = st_wdata;
                    ld_size_d = memSize_i;
                    ld_off_d  = addr_i[1:0];
                    ld_uns_d  = memUnsigned_i;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem.gnt) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b0;
                end else if (timeout) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    rd_data_d = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem.rvalid) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    rd_data_d = we_q ? '0 : ld_data;
                end else if (timeout) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    rd_data_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o      = access & ~misalign;
                misaligned_o = access & misalign;
            end
            ST_REQ, ST_WAIT: stall_o = 1'b1;
            default: ;
        endcase
    end

    assign done_o     = done_q;
    assign busErr_o   = bus_err_q;
    assign rdData_o   = rd_data_q;
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM register and the MEM/WB register.
- Takes the ALU result (address), store data and memory controls, and runs a req/gnt/rvalid handshake to data memory.
- Aligns and extends load data, and stalls the pipeline until the access completes.
- Its rdData_o feeds the MEM/WB register's rdData_i.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before a bus error is forced (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction in MEM stage is valid
- memRead_i  in  1  load
- memWrite_i  in  1  store (memRead_i and memWrite_i are never both 1)
- memSize_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- memUnsigned_i  in  1  zero-extend loads
- addr_i  in  32  byte address (ALU result)
- storeData_i  in  32  rs2 value
- stall_o  out  1  hold IF..MEM stages
- done_o  out  1  access completes this cycle
- misaligned_o  out  1  alignment fault, one cycle
- busErr_o  out  1  timeout fault, one cycle
- rdData_o  out  32  extended load result
- dmem_req_o  out  1  request
- dmem_we_o  out  1  write
- dmem_addr_o  out  32  word address, {addr_i[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response / write acknowledge
- dmem_rdata_i  in  32  read word

Behaviour:
- Reset is asynchronous and active-low. While rst=0: state=IDLE, counter=0, all registered outputs 0 (rdData_o, done_o, busErr_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o).
- access = valid_i & (memRead_i | memWrite_i).
- misalign = half with addr_i[0]=1, or word with addr_i[1:0]!=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - access & !misalign → REQ. Register dmem_addr_o, dmem_we_o=memWrite_i, dmem_be_o, dmem_wdata_o; set dmem_req_o=1. stall_o=1 (combinational).
  - access & misalign → stay IDLE. misaligned_o=1 (combinational), stall_o=0, no request.
  - otherwise stall_o=0.
- REQ: stall_o=1. dmem_req_o and its address/we/be/wdata stay stable until dmem_gnt_i. On gnt → WAIT and drop dmem_req_o.
- WAIT: stall_o=1. On dmem_rvalid_i → DONE, and rdData_o is registered from dmem_rdata_i after extension (0 for stores).
- DONE: stall_o=0, done_o=1 for one cycle, then → IDLE. The MEM/WB register captures rdData_o at the end of this cycle.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the next cycle: 3 stall cycles, then DONE.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT → DONE with busErr_o=1, rdData_o=0, dmem_req_o=0.
  - gnt/rvalid arriving in the same cycle as the timeout: the normal transition wins.
- Byte enables: byte → 4'b0001<<addr_i[1:0]; half → 4'b0011<<{addr_i[1],1'b0}; word → 4'b1111.
- Store data: byte → {4{storeData_i[7:0]}}; half → {2{storeData_i[15:0]}}; word unchanged.
- Loads: select the lane at addr_i[1:0] (half at addr_i[1]), then sign- or zero-extend per memUnsigned_i.
- Ignored events: dmem_gnt_i outside REQ, dmem_rvalid_i outside WAIT (including stale responses after reset), rvalid in the same cycle as gnt.
- Inputs are held stable by the stall; the block never re-samples them outside IDLE.
- No back-to-back issue from DONE: a following access starts from IDLE on the next cycle.

Decomposition:
- Shared Types.v gains:
  - mem size encodings: MEM_BYTE / MEM_HALF / MEM_WORD
  - `memSize 2-bit type
  - `byteEn 4-bit type
- Reuse existing `data for data-width signals.
- One sub-module, mem_lane_align (combinational): byte-enable generation, store replication, load lane select and extension. The FSM and counter stay in mem_access_unit.

Test Plan:
- Load word at addr 0x100, gnt on the first REQ cycle, rvalid next with rdata 0xDEADBEEF → stall_o high 3 cycles, done_o 1 cycle, rdData_o=0xDEADBEEF, dmem_be_o=4'b1111, dmem_addr_o=0x100.
- Load byte, signed then unsigned, at addr 0x103 with rdata 0x80FF1234 → rdData_o=0xFFFFFF80, then 0x00000080; dmem_be_o=4'b1000.
- Store half, storeData 0x0000ABCD at addr 0x202, gnt delayed 4 cycles → req and address held stable for all 4 cycles, dmem_wdata_o=0xABCDABCD, dmem_be_o=4'b1100, dmem_we_o=1, done_o after rvalid.
- Load word at addr 0x101 → misaligned_o=1 for one cycle, stall_o=0, dmem_req_o never asserted.
- TIMEOUT=8, gnt given, rvalid never arrives → busErr_o=1 and done_o=1 exactly 8 cycles after entering REQ, rdData_o=0, then IDLE.
- rst pulled low while in WAIT, then a stale rvalid arrives after release → all outputs 0, state IDLE, the stale rvalid is ignored, and the next load completes normally.
